freq_eq_mac: RTL

- Frequency-domain equalizer MAC stage, directly downstream of the history buffer, in the FFT-based overlap-save equalizer path.
- Per FFT bin k it computes Y[k] = X_curr[k]*W0[k] + X_old[k]*W1[k], a two-partition complex multiply-accumulate.
- Rounds and saturates the result back to W bits, tags each output with its bin index and an end-of-block marker, and feeds the IFFT.

---
 rtl/fde_pkg.sv | 46 ++++
 rtl/cmul_pair.sv | 79 +++++++
 rtl/freq_eq_mac.sv | 98 +++++++++
 3 files changed

// File: rtl/fde_pkg.sv
// fde_pkg: shared fixed-point definitions for the frequency-domain equalizer path.
// Contents: data widths, bins per block, Q-format constants, saturation limits and
// a round-and-saturate helper that is also used by the IFFT scaling stage.
package fde_pkg;

  localparam int unsigned W    = 16;  // signed data / coefficient width per component
  localparam int unsigned FRAC = 14;  // fractional bits, 1.0 == 2^FRAC
  localparam int unsigned NFFT = 32;  // bins per block, power of two <= 32

  localparam int unsigned IdxW  = 5;
  localparam int unsigned ProdW = 2 * W;
  // Four 2W-bit products summed: two guard bits make overflow impossible.
  localparam int unsigned AccW  = 2 * W + 2;

  localparam int unsigned One     = 1 << FRAC;
  localparam int unsigned HalfLsb = 1 << (FRAC - 1);

  localparam logic signed [W-1:0] SatMax = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SatMin = {1'b1, {(W-1){1'b0}}};

  typedef struct packed {
    logic signed [W-1:0] y;
    logic                sat;
  } rs_t;

  // Round half up, arithmetic shift by FRAC, clip to the W-bit signed range.
  function automatic rs_t round_sat(input logic signed [AccW-1:0] acc);
    logic signed [AccW:0]      sum;
    logic signed [AccW-FRAC:0] shr;
    rs_t                       r;
    sum = $signed({acc[AccW-1], acc}) + $signed((AccW + 1)'(HalfLsb));
    shr = sum[AccW:FRAC];
    if (shr > SatMax) begin
      r.y   = SatMax;
      r.sat = 1'b1;
    end else if (shr < SatMin) begin
      r.y   = SatMin;
      r.sat = 1'b1;
    end else begin
      r.y   = shr[W-1:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmul_pair.sv
// cmul_pair: two complex multiplies and their accumulation (equalizer stages S1-S2).
// S1 registers the eight real products, S2 registers the sign-extended sums:
//   re = Xc.re*W0.re - Xc.im*W0.im + Xo.re*W1.re - Xo.im*W1.im
//   im = Xc.re*W0.im + Xc.im*W0.re + Xo.re*W1.im + Xo.im*W1.re
// Ports: clk, rst (async active-low), i_valid + eight W-bit signed operands in;
//        o_valid (i_valid delayed by 2) and AccW-bit o_re_acc / o_im_acc out.
module cmul_pair
  import fde_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic signed [W-1:0]    i_xc_re,
  input  logic signed [W-1:0]    i_xc_im,
  input  logic signed [W-1:0]    i_xo_re,
  input  logic signed [W-1:0]    i_xo_im,
  input  logic signed [W-1:0]    i_w0_re,
  input  logic signed [W-1:0]    i_w0_im,
  input  logic signed [W-1:0]    i_w1_re,
  input  logic signed [W-1:0]    i_w1_im,
  output logic                   o_valid,
  output logic signed [AccW-1:0] o_re_acc,
  output logic signed [AccW-1:0] o_im_acc
);

  function automatic logic signed [AccW-1:0] sext(input logic signed [ProdW-1:0] p);
    return {{(AccW - ProdW){p[ProdW-1]}}, p};
  endfunction

  logic                    v1_q, v2_q;
  logic signed [ProdW-1:0] cur_rr_q, cur_ii_q, cur_ri_q, cur_ir_q;
  logic signed [ProdW-1:0] old_rr_q, old_ii_q, old_ri_q, old_ir_q;
  logic signed [AccW-1:0]  re_acc_q, im_acc_q;
  logic signed [AccW-1:0]  re_acc_d, im_acc_d;

  always_comb begin
    re_acc_d = sext(cur_rr_q) - sext(cur_ii_q) + sext(old_rr_q) - sext(old_ii_q);
    im_acc_d = sext(cur_ri_q) + sext(cur_ir_q) + sext(old_ri_q) + sext(old_ir_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      cur_rr_q <= '0;
      cur_ii_q <= '0;
      cur_ri_q <= '0;
      cur_ir_q <= '0;
      old_rr_q <= '0;
      old_ii_q <= '0;
      old_ri_q <= '0;
      old_ir_q <= '0;
      re_acc_q <= '0;
      im_acc_q <= '0;
    end else begin
      v1_q <= i_valid;
      v2_q <= v1_q;
      if (i_valid) begin
        cur_rr_q <= i_xc_re * i_w0_re;
        cur_ii_q <= i_xc_im * i_w0_im;
        cur_ri_q <= i_xc_re * i_w0_im;
        cur_ir_q <= i_xc_im * i_w0_re;
        old_rr_q <= i_xo_re * i_w1_re;
        old_ii_q <= i_xo_im * i_w1_im;
        old_ri_q <= i_xo_re * i_w1_im;
        old_ir_q <= i_xo_im * i_w1_re;
      end
      if (v1_q) begin
        re_acc_q <= re_acc_d;
        im_acc_q <= im_acc_d;
      end
    end
  end

  assign o_valid  = v2_q;
  assign o_re_acc = re_acc_q;
  assign o_im_acc = im_acc_q;

endmodule

// File: rtl/freq_eq_mac.sv
// freq_eq_mac: frequency-domain equalizer MAC, Y[k] = Xc[k]*W0[k] + Xo[k]*W1[k].
// Three-stage pipeline, one bin per cycle, no backpressure: cmul_pair (S1-S2) then
// round/saturate (S3) with bin index, end-of-block and saturation flags.
// Ports: clk, rst (async active-low); i_valid plus Xc/Xo/W0/W1 complex operands and
//        i_clr_sat in; o_valid, o_Y_re/o_Y_im, o_k_idx, o_last, o_sat, o_sat_sticky out.
module freq_eq_mac
  import fde_pkg::*;
#(
  parameter int unsigned Nfft = NFFT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic signed [W-1:0] i_X_curr_re,
  input  logic signed [W-1:0] i_X_curr_im,
  input  logic signed [W-1:0] i_X_old_re,
  input  logic signed [W-1:0] i_X_old_im,
  input  logic signed [W-1:0] i_W0_re,
  input  logic signed [W-1:0] i_W0_im,
  input  logic signed [W-1:0] i_W1_re,
  input  logic signed [W-1:0] i_W1_im,
  input  logic                i_clr_sat,
  output logic                o_valid,
  output logic signed [W-1:0] o_Y_re,
  output logic signed [W-1:0] o_Y_im,
  output logic [IdxW-1:0]     o_k_idx,
  output logic                o_last,
  output logic                o_sat,
  output logic                o_sat_sticky
);

  logic                   v2;
  logic signed [AccW-1:0] re_acc, im_acc;

  cmul_pair u_cmul_pair (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .i_xc_re  (i_X_curr_re),
    .i_xc_im  (i_X_curr_im),
    .i_xo_re  (i_X_old_re),
    .i_xo_im  (i_X_old_im),
    .i_w0_re  (i_W0_re),
    .i_w0_im  (i_W0_im),
    .i_w1_re  (i_W1_re),
    .i_w1_im  (i_W1_im),
    .o_valid  (v2),
    .o_re_acc (re_acc),
    .o_im_acc (im_acc)
  );

  logic                valid_q, sat_q, sticky_q;
  logic signed [W-1:0] y_re_q, y_im_q;
  logic [IdxW-1:0]     idx_q, idx_d;
  rs_t                 rs_re, rs_im;
  logic                sat_d;

  always_comb begin
    rs_re = round_sat(re_acc);
    rs_im = round_sat(im_acc);
    sat_d = v2 & (rs_re.sat | rs_im.sat);
    // Index restarts at 0 after any gap; otherwise counts and wraps at Nfft-1.
    idx_d = '0;
    if (v2 && valid_q && (idx_q != IdxW'(Nfft - 1))) begin
      idx_d = idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
      sticky_q <= 1'b0;
      y_re_q   <= '0;
      y_im_q   <= '0;
      idx_q    <= '0;
    end else begin
      valid_q  <= v2;
      sat_q    <= sat_d;
      idx_q    <= idx_d;
      // Set beats clear when both land in the same cycle.
      sticky_q <= sat_d | (sticky_q & ~i_clr_sat);
      if (v2) begin
        y_re_q <= rs_re.y;
        y_im_q <= rs_im.y;
      end
    end
  end

  assign o_valid      = valid_q;
  assign o_Y_re       = y_re_q;
  assign o_Y_im       = y_im_q;
  assign o_k_idx      = idx_q;
  assign o_last       = valid_q & (idx_q == IdxW'(Nfft - 1));
  assign o_sat        = sat_q;
  assign o_sat_sticky = sticky_q;

endmodule
